// File: rtl/sobel3x3_lb_pkg.sv
// sobel3x3_lb_pkg: shared preproc encodings, latency and saturation helper
package sobel3x3_lb_pkg;
  localparam logic [1:0] MODE_GX  = 2'd0;
  localparam logic [1:0] MODE_GY  = 2'd1;
  localparam logic [1:0] MODE_SUM = 2'd2;
  localparam int SOBEL_LAT = 3;

  function automatic logic [31:0] sat(input logic [31:0] v, input int unsigned dw);
    logic [31:0] mx;
    mx = (32'd1 << dw) - 32'd1;
    return (v > mx) ? mx : v;
  endfunction
endpackage

// File: rtl/sobel3x3_lb_linebuf.sv
// sobel_linebuf: one image line of storage, read-before-write at a single address
module sobel_linebuf #(
  parameter int DW    = 8,
  parameter int DEPTH = 640
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DW-1:0]            din,
  output logic [DW-1:0]            dout
);
  logic [DW-1:0] mem [DEPTH];

  assign dout = mem[addr];

  // old contents are read out in the same cycle the new pixel overwrites them
  always_ff @(posedge clk)
    if (we) mem[addr] <= din;
endmodule

// File: rtl/sobel3x3_lb.sv
// sobel3x3_lb: streaming 3x3 Sobel gradient magnitude with two line buffers
module sobel3x3_lb
  import sobel3x3_lb_pkg::*;
#(
  parameter int DW    = 8,
  parameter int IMG_W = 640,
  parameter int SHIFT = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_vld,
  input  logic          i_sof,
  input  logic          i_eol,
  input  logic [DW-1:0] i_pix,
  input  logic [1:0]    i_mode,
  output logic          o_vld,
  output logic          o_sof,
  output logic          o_eol,
  output logic [DW-1:0] o_mag,
  output logic          o_line_err
);
  localparam int AW = $clog2(IMG_W);
  localparam int GW = DW + 3;
  localparam int MW = DW + 2;

  logic [AW-1:0] col_cnt, col_eff;
  logic [1:0] row_cnt, row_eff, mode_q, mode_eff, md1, md2;
  logic start, last, err, bd1, bd2;
  logic [DW-1:0] lb0_q, lb1_q;
  logic [2:0][DW-1:0] w0, w1, w2;
  logic [SOBEL_LAT-1:0] vld_sr, sof_sr, eol_sr, err_sr;
  logic [GW-1:0] gx, gy, sel;
  logic [MW-1:0] ax, ay;

  function automatic logic [GW-1:0] tri3(input logic [DW-1:0] a, b, c);
    return GW'(a) + (GW'(b) << 1) + GW'(c);
  endfunction

  assign start    = i_vld & i_sof;
  assign col_eff  = start ? '0 : col_cnt;
  assign row_eff  = start ? '0 : row_cnt;
  assign mode_eff = start ? i_mode : mode_q;
  assign last     = col_eff == AW'(IMG_W - 1);
  assign err      = i_vld & (i_eol ^ last);

  sobel_linebuf #(.DW(DW), .DEPTH(IMG_W)) u_lb1 (.clk(clk), .we(i_vld), .addr(col_eff), .din(i_pix), .dout(lb1_q));
  sobel_linebuf #(.DW(DW), .DEPTH(IMG_W)) u_lb0 (.clk(clk), .we(i_vld), .addr(col_eff), .din(lb1_q), .dout(lb0_q));

  // raster position and gradient mode, restarted by every sof
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      col_cnt <= '0;
      row_cnt <= '0;
      mode_q  <= MODE_SUM;
    end else if (i_vld) begin
      col_cnt <= last ? '0 : col_eff + 1'b1;
      row_cnt <= (last && row_eff != 2'd2) ? row_eff + 2'd1 : row_eff;
      mode_q  <= mode_eff;
    end

  // stage 1: shift a new column into the window and tag the pixel
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      w0 <= '0;
      w1 <= '0;
      w2 <= '0;
      bd1 <= 1'b0;
      md1 <= MODE_SUM;
      vld_sr <= '0;
      sof_sr <= '0;
      eol_sr <= '0;
      err_sr <= '0;
    end else begin
      vld_sr <= {vld_sr[SOBEL_LAT-2:0], i_vld};
      sof_sr <= {sof_sr[SOBEL_LAT-2:0], start};
      eol_sr <= {eol_sr[SOBEL_LAT-2:0], i_vld & i_eol};
      err_sr <= {err_sr[SOBEL_LAT-2:0], err};
      if (i_vld) begin
        w0 <= {lb0_q, w0[2:1]};
        w1 <= {lb1_q, w1[2:1]};
        w2 <= {i_pix, w2[2:1]};
        bd1 <= (row_eff < 2'd2) || (col_eff < AW'(2));
        md1 <= mode_eff;
      end
    end

  // stage 2: signed horizontal and vertical gradients
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      gx <= '0;
      gy <= '0;
      bd2 <= 1'b0;
      md2 <= MODE_SUM;
    end else begin
      gx <= tri3(w0[2], w1[2], w2[2]) - tri3(w0[0], w1[0], w2[0]);
      gy <= tri3(w2[0], w2[1], w2[2]) - tri3(w0[0], w0[1], w0[2]);
      bd2 <= bd1;
      md2 <= md1;
    end

  // stage 3 operands: absolute values and mode selection
  always_comb begin
    ax = gx[GW-1] ? MW'(-gx) : MW'(gx);
    ay = gy[GW-1] ? MW'(-gy) : MW'(gy);
    sel = md2 == MODE_GX ? GW'(ax) : md2 == MODE_GY ? GW'(ay) : GW'(ax) + GW'(ay);
  end

  // stage 3: scale, saturate and blank the border
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) o_mag <= '0;
    else o_mag <= bd2 ? '0 : DW'(sat(32'(sel >> SHIFT), DW));

  assign o_vld      = vld_sr[SOBEL_LAT-1];
  assign o_sof      = sof_sr[SOBEL_LAT-1];
  assign o_eol      = eol_sr[SOBEL_LAT-1];
  assign o_line_err = err_sr[SOBEL_LAT-1];
endmodule

// File: doc/sobel3x3_lb.md
Name: sobel3x3_lb

Overview:
- Full 2-D 3x3 Sobel gradient on a raster pixel stream.
- Generalised in pixel width, line length, output scaling and gradient mode.
- Two on-chip line buffers; frame/line sync carried alongside the data.
- Sits in the preproc chain after grey conversion and before thresholding/feature stages; no backpressure.

Parameters:
- DW, 8, pixel and magnitude width in bits.
- IMG_W, 640, active pixels per line, >= 4.
- SHIFT, 0, right shift applied to the combined magnitude before saturation, 0..3.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- i_vld  in  1  input pixel valid
- i_sof  in  1  first pixel of frame, qualified by i_vld
- i_eol  in  1  last pixel of line, qualified by i_vld
- i_pix  in  DW  input pixel, unsigned
- i_mode  in  2  0=|Gx|, 1=|Gy|, 2 and 3=|Gx|+|Gy|; sampled on i_vld&i_sof
- o_vld  out  1  output valid
- o_sof  out  1  i_sof delayed
- o_eol  out  1  i_eol delayed
- o_mag  out  DW  gradient magnitude, saturated
- o_line_err  out  1  one-cycle pulse on line-length mismatch

Behaviour:
- Reset: all outputs 0; col_cnt=0; row_cnt=0; window regs=0; mode_q=2.
  - Line buffer RAM contents are not reset.
- Counters and window advance only when i_vld=1. Gaps in i_vld are transparent to the result.
- Counters:
  - col_cnt runs 0..IMG_W-1, then wraps to 0; row_cnt increments on wrap and saturates at 2.
  - i_vld&i_sof forces col_cnt=0 and row_cnt=0 for that pixel, overriding the current count (restart mid-frame allowed).
- Line buffers (one per row, IMG_W deep, addressed by col_cnt):
  - Read-before-write.
  - lb1 out goes to window row 1; lb1 in = i_pix.
  - lb0 out goes to window row 0; lb0 in = lb1 out.
- Window:
  - 3x3 regs pRC; R=0 oldest row, C=0 oldest column; new column shifted in each i_vld.
  - Centre is input position (row-1, col-1): output spatially lags by one row and one column.
- Arithmetic, signed, width DW+3:
  - Gx = (p02+2p12+p22) - (p00+2p10+p20)
  - Gy = (p20+2p21+p22) - (p00+2p01+p02)
  - Abs values are DW+2 bits unsigned; the sum is DW+3 bits unsigned.
  - Select per mode_q, shift right by SHIFT, saturate to 2^DW-1.
- Border mask: o_mag=0 when the tagged row_cnt<2 or col_cnt<2 for that pixel. o_vld is still asserted.
- Pipeline: stage 1 window load, stage 2 Gx/Gy, stage 3 abs/select/saturate.
  - o_vld/o_sof/o_eol = i_vld/i_sof/i_eol delayed exactly 3 clk cycles, regardless of gaps.
  - Border flag travels with the data.
- Mode: mode_q updates on i_vld&i_sof and applies from that pixel onward. i_mode is ignored at other times.
- o_line_err pulses one cycle (aligned with o_eol) when either:
  - i_eol arrives with col_cnt != IMG_W-1, or
  - col_cnt wraps without i_eol.
  - Counters do not resync on eol; only sof resyncs.
- Before the first sof after reset, the stream is treated as row 0.
- Reset mid-frame: pipeline flushes with no o_vld; the next valid frame must begin with sof.

Decomposition:
- Shared preproc package:
  - Mode encodings MODE_GX=0, MODE_GY=1, MODE_SUM=2.
  - Latency constant SOBEL_LAT=3.
  - Saturate function.
- One sub-module, sobel_linebuf: parametrised IMG_W x DW single-port read-before-write RAM, instantiated twice, inferable as block RAM.

Test Plan (DW=8, IMG_W=8 unless noted):
- Constant frame of 100, mode 2 -> all o_mag=0; o_vld count equals i_vld count; o_sof exactly 3 cycles after i_sof.
- Vertical edge (cols 0-3 = 0, 4-7 = 255), mode 0:
  - Non-border outputs at the edge centres = 255 (saturated from 1020).
  - With SHIFT=2 -> 255; at col 3/4 centres with 16 vs 0 and SHIFT=2 -> 16.
  - Flat areas -> 0.
- Horizontal edge (rows 0-3 = 0, rows 4+ = 10), mode 1 -> 40 on edge centres, 0 elsewhere; mode 0 -> 0 everywhere.
- Border: rows 0-1 and cols 0-1 of every frame -> o_mag=0 even with a random image; second frame sof mid-line resets counters, and its first two rows are 0.
- Random i_vld gaps (50% duty) with a random image -> o_mag sequence identical to a gap-free run; latency stays 3 cycles.
- Line error: i_eol on col 5 -> o_line_err one pulse aligned with o_eol. Reset asserted mid-frame -> all outputs 0 next cycle; no o_vld until new input arrives.
